lsq_seq_ctrl: RTL

Sequencer for the least-squares regression datapath in the option-pricing engine. It streams a block of path samples out of the sample buffer into the power-sum (XᵀX) and cross-product (XᵀY) accumulators. It then runs the 3×3 matrix inversion and signals when the regression coefficients may be latched. It is the only block that drives the accumulator clear/enable and inversion start controls.

---
 rtl/lsq_pkg.sv | 18 +
 rtl/lsq_addr_cnt.sv | 31 +++
 rtl/lsq_seq_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lsq_pkg.sv
// Shared definitions for the least-squares regression sequencer and accumulators.
// Holds the sequencer state type and the default block geometry.
package lsq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_INVERT,
        ST_SOLVE
    } lsq_state_t;

    localparam int unsigned LSQ_N_SAMPLES   = 1024;
    localparam int unsigned LSQ_ADDR_W      = 10;
    localparam int unsigned LSQ_INV_TIMEOUT = 64;

endpackage

// File: rtl/lsq_addr_cnt.sv
// Sample-buffer address counter: load-zero, increment, and terminal count at N_SAMPLES-1.
// The terminal compare is against N_SAMPLES-1, so a full 2^ADDR_W pass never relies on overflow.
module lsq_addr_cnt
    import lsq_pkg::*;
#(
    parameter int unsigned ADDR_W    = LSQ_ADDR_W,
    parameter int unsigned N_SAMPLES = LSQ_N_SAMPLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
        end
    end

    assign tc = (addr == LAST_ADDR);

endmodule

// File: rtl/lsq_seq_ctrl.sv
// Sequencer streaming samples into the XtX/XtY accumulators, then running the 3x3 inversion.
// Define LSQ_INV_TIMEOUT_EN to bound the inversion wait by INV_TIMEOUT cycles and report err.
module lsq_seq_ctrl
    import lsq_pkg::*;
#(
    parameter int unsigned N_SAMPLES   = LSQ_N_SAMPLES,
    parameter int unsigned ADDR_W      = LSQ_ADDR_W,
    parameter int unsigned INV_TIMEOUT = LSQ_INV_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              inv_start,
    input  logic              inv_valid,
    output logic              coef_latch
);

    if (N_SAMPLES < 1 || (2 ** ADDR_W) < N_SAMPLES || INV_TIMEOUT < 1) begin : g_bad_cfg
        $error("lsq_seq_ctrl: invalid N_SAMPLES/ADDR_W/INV_TIMEOUT combination");
    end

    lsq_state_t state, state_nx;
    logic       addr_tc;
    logic       timeout;

    lsq_addr_cnt #(
        .ADDR_W    (ADDR_W),
        .N_SAMPLES (N_SAMPLES)
    ) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_nx != ST_ACCUM),
        .inc   (state == ST_ACCUM),
        .addr  (mem_addr),
        .tc    (addr_tc)
    );

`ifdef LSQ_INV_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(INV_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != ST_INVERT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires on the last permitted INVERT cycle; a valid on that same cycle still wins.
    assign timeout = (state == ST_INVERT) && (to_cnt == TO_W'(INV_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= timeout && !inv_valid && !abort;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_CLEAR;
            ST_CLEAR:  state_nx = ST_ACCUM;
            ST_ACCUM:  if (addr_tc) state_nx = ST_DRAIN;
            ST_DRAIN:  state_nx = ST_INVERT;
            ST_INVERT: begin
                if (inv_valid) begin
                    state_nx = ST_SOLVE;
                end else if (timeout) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SOLVE:  state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
        if (abort) begin
            state_nx = ST_IDLE;
        end
    end

    // Outputs are registered from the next state so each one is aligned with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            acc_clr    <= 1'b0;
            mem_rd_en  <= 1'b0;
            acc_en     <= 1'b0;
            inv_start  <= 1'b0;
            done       <= 1'b0;
            coef_latch <= 1'b0;
        end else begin
            state      <= state_nx;
            busy       <= (state_nx != ST_IDLE);
            acc_clr    <= (state_nx == ST_CLEAR);
            mem_rd_en  <= (state_nx == ST_ACCUM);
            acc_en     <= mem_rd_en && !abort;
            inv_start  <= (state_nx == ST_INVERT);
            done       <= (state_nx == ST_SOLVE);
            coef_latch <= (state_nx == ST_SOLVE);
        end
    end

endmodule
